phase_scheduler: RTL and testbench

//  Per-pixel sequencer sharing one atan unit across all zeros/poles of the transfer function.
//  For each accepted pixel (x,y) it issues each (pixel - root) difference to the shared atan

---
 rtl/pixgen_pkg.sv | 28 ++
 rtl/phase_scheduler_if.sv | 41 ++++
 rtl/phase_scheduler_root_shadow_reg.sv | 28 ++
 rtl/phase_scheduler.sv | 159 +++++++++++++++
 tb/tb_phase_scheduler.sv | 360 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pixgen_pkg.sv
// Shared constants and types for the pixel-generation pipeline.
package pixgen_pkg;

    localparam int unsigned PIX_W  = 16;
    localparam int unsigned ROOT_W = 32;

    // Field offsets of one packed root: re in the upper half, im in the lower half
    localparam int unsigned RE_MSB = 31;
    localparam int unsigned RE_LSB = 16;
    localparam int unsigned IM_MSB = 15;
    localparam int unsigned IM_LSB = 0;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_OUT   = 2'd3;

    localparam logic [1:0] AXI_OK  = 2'b00;
    localparam logic [1:0] AXI_ERR = 2'b10;

    // Travels alongside each atan request so its result can be folded in on return
    typedef struct packed {
        logic valid;
        logic is_pole;
        logic enabled;
    } tag_t;

endpackage

// File: rtl/phase_scheduler_if.sv
// Pixel-in, shared-atan and phase-out handshakes of the phase scheduler.
interface phase_scheduler_if;
    import pixgen_pkg::*;

    logic [PIX_W-1:0] in_x;
    logic [PIX_W-1:0] in_y;
    logic             in_first;
    logic             in_lastx;
    logic             in_valid;
    logic             in_ready;

    logic [PIX_W-1:0] atan_x;
    logic [PIX_W-1:0] atan_y;
    logic             atan_valid;
    logic [PIX_W-1:0] atan_angle;

    logic [PIX_W-1:0] out_phase;
    logic             out_first;
    logic             out_lastx;
    logic             out_valid;
    logic             out_ready;

    modport slave (
        input  in_x, in_y, in_first, in_lastx, in_valid,
        output in_ready,
        output atan_x, atan_y, atan_valid,
        input  atan_angle,
        output out_phase, out_first, out_lastx, out_valid,
        input  out_ready
    );

    modport master (
        output in_x, in_y, in_first, in_lastx, in_valid,
        input  in_ready,
        input  atan_x, atan_y, atan_valid,
        output atan_angle,
        input  out_phase, out_first, out_lastx, out_valid,
        output out_ready
    );

endinterface

// File: rtl/phase_scheduler_root_shadow_reg.sv
// Frame-latched copy of the root configuration; zeros occupy the low slots, poles the high.
module root_shadow_reg
    import pixgen_pkg::*;
#(
    parameter int unsigned N_ZEROS = 4,
    parameter int unsigned N_POLES = 4
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                load,
    input  logic [ROOT_W*N_ZEROS-1:0]           cfg_zeros,
    input  logic [ROOT_W*N_POLES-1:0]           cfg_poles,
    input  logic [N_ZEROS+N_POLES-1:0]          cfg_mask,
    output logic [ROOT_W*(N_ZEROS+N_POLES)-1:0] shadow_roots,
    output logic [N_ZEROS+N_POLES-1:0]          shadow_mask
);

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_roots <= '0;
            shadow_mask  <= '0;
        end else if (load) begin
            shadow_roots <= {cfg_poles, cfg_zeros};
            shadow_mask  <= cfg_mask;
        end
    end

endmodule

// File: rtl/phase_scheduler.sv
// Per-pixel sequencer: issues every (pixel - root) difference to one shared atan unit
// and accumulates sum(zero angles) - sum(pole angles) modulo 2^16.
module phase_scheduler
    import pixgen_pkg::*;
#(
    parameter int unsigned N_ZEROS  = 4,
    parameter int unsigned N_POLES  = 4,
    parameter int unsigned ATAN_LAT = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [ROOT_W*N_ZEROS-1:0]  cfg_zeros,
    input  logic [ROOT_W*N_POLES-1:0]  cfg_poles,
    input  logic [N_ZEROS+N_POLES-1:0] cfg_mask,
    phase_scheduler_if.slave           ifc
);

    localparam int unsigned NR      = N_ZEROS + N_POLES;
    localparam int unsigned CNT_MAX = (NR > ATAN_LAT) ? NR : ATAN_LAT;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned SLOT_W  = (NR > 1) ? $clog2(NR) : 1;

    logic [1:0]             state, state_d;
    logic [CNT_W-1:0]       cnt, cnt_d;
    logic [PIX_W-1:0]       px, py;
    logic [PIX_W-1:0]       acc;
    tag_t                   tag_q [ATAN_LAT+1];
    tag_t                   tag_in;
    logic                   in_ready_d, out_valid_d, atan_valid_d, issue;
    logic [PIX_W-1:0]       atan_x_d, atan_y_d;
    logic                   accept, load;
    logic [ROOT_W*NR-1:0]   shadow_roots, src_roots;
    logic [NR-1:0]          shadow_mask, src_mask;
    logic [SLOT_W-1:0]      slot;
    logic [ROOT_W-1:0]      root;
    logic [PIX_W-1:0]       op_x, op_y;

    assign accept = (state == ST_IDLE) && ifc.in_valid && ifc.in_ready;
    assign load   = accept && ifc.in_first;

    root_shadow_reg #(
        .N_ZEROS (N_ZEROS),
        .N_POLES (N_POLES)
    ) u_root_shadow (
        .clk          (clk),
        .reset        (reset),
        .load         (load),
        .cfg_zeros    (cfg_zeros),
        .cfg_poles    (cfg_poles),
        .cfg_mask     (cfg_mask),
        .shadow_roots (shadow_roots),
        .shadow_mask  (shadow_mask)
    );

    // Slot 0 issues on the accept edge, the same edge the shadow loads, so read live cfg then
    assign src_roots = load ? {cfg_poles, cfg_zeros} : shadow_roots;
    assign src_mask  = load ? cfg_mask : shadow_mask;
    assign slot      = (state == ST_IDLE) ? '0 : SLOT_W'(cnt);
    assign root      = src_roots[ROOT_W*32'(slot) +: ROOT_W];
    assign op_x      = ((state == ST_IDLE) ? ifc.in_x : px) - root[RE_MSB:RE_LSB];
    assign op_y      = ((state == ST_IDLE) ? ifc.in_y : py) - root[IM_MSB:IM_LSB];

    // Next-state and next-output logic; cnt is the next slot in ISSUE, remaining wait in DRAIN
    always_comb begin
        state_d      = state;
        cnt_d        = cnt;
        in_ready_d   = ifc.in_ready;
        out_valid_d  = ifc.out_valid;
        atan_valid_d = 1'b0;
        atan_x_d     = ifc.atan_x;
        atan_y_d     = ifc.atan_y;
        tag_in       = '0;
        issue        = 1'b0;

        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_d    = ST_ISSUE;
                    cnt_d      = CNT_W'(1);
                    in_ready_d = 1'b0;
                    issue      = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (cnt == CNT_W'(NR)) begin
                    state_d = ST_DRAIN;
                    cnt_d   = CNT_W'(ATAN_LAT - 1);
                end else begin
                    issue = 1'b1;
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            ST_DRAIN: begin
                if (cnt == '0) begin
                    state_d     = ST_OUT;
                    out_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            ST_OUT: begin
                if (ifc.out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (issue) begin
            atan_valid_d = 1'b1;
            atan_x_d     = op_x;
            atan_y_d     = op_y;
            tag_in       = '{valid: 1'b1, is_pole: (32'(slot) >= N_ZEROS), enabled: src_mask[slot]};
        end
    end

    assign ifc.out_phase = acc;

    // State, registered outputs, tag pipeline and phase accumulator
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            cnt            <= '0;
            px             <= '0;
            py             <= '0;
            acc            <= '0;
            ifc.in_ready   <= 1'b1;
            ifc.atan_valid <= 1'b0;
            ifc.atan_x     <= '0;
            ifc.atan_y     <= '0;
            ifc.out_valid  <= 1'b0;
            ifc.out_first  <= 1'b0;
            ifc.out_lastx  <= 1'b0;
            for (int i = 0; i <= ATAN_LAT; i++) tag_q[i] <= '0;
        end else begin
            state          <= state_d;
            cnt            <= cnt_d;
            ifc.in_ready   <= in_ready_d;
            ifc.atan_valid <= atan_valid_d;
            ifc.atan_x     <= atan_x_d;
            ifc.atan_y     <= atan_y_d;
            ifc.out_valid  <= out_valid_d;
            tag_q[0]       <= tag_in;
            for (int i = 1; i <= ATAN_LAT; i++) tag_q[i] <= tag_q[i-1];
            if (accept) begin
                px            <= ifc.in_x;
                py            <= ifc.in_y;
                ifc.out_first <= ifc.in_first;
                ifc.out_lastx <= ifc.in_lastx;
                acc           <= '0;
            end else if (tag_q[ATAN_LAT].valid && tag_q[ATAN_LAT].enabled) begin
                acc <= tag_q[ATAN_LAT].is_pole ? (acc - ifc.atan_angle) : (acc + ifc.atan_angle);
            end
        end
    end

endmodule

// File: tb/tb_phase_scheduler.sv
// Bench for phase_scheduler: directed corner cases plus randomized pixels, all checked
// against a per-pixel behavioural model of issue timing, operands and accumulated phase.
module tb_phase_scheduler;

    localparam int NZ  = 4;
    localparam int NP  = 4;
    localparam int NR  = NZ + NP;
    localparam int LAT = 2;

    logic             clk   = 1'b0;
    logic             reset = 1'b1;
    logic [32*NZ-1:0] cfg_zeros = '0;
    logic [32*NP-1:0] cfg_poles = '0;
    logic [NR-1:0]    cfg_mask  = '0;

    int checks     = 0;
    int failures   = 0;
    int ready_mode = 0;

    phase_scheduler_if ifc ();

    phase_scheduler #(
        .N_ZEROS  (NZ),
        .N_POLES  (NP),
        .ATAN_LAT (LAT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_zeros (cfg_zeros),
        .cfg_poles (cfg_poles),
        .cfg_mask  (cfg_mask),
        .ifc       (ifc)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s timeout actual=expired required=event at %0t", name, $time);
    endtask

    function automatic logic [15:0] stub(input logic [15:0] ax, input logic [15:0] ay);
        return {ax[7:0], ay[7:0]};
    endfunction

    // atan stub: angle of an issued operand pair appears exactly LAT cycles later
    initial begin
        logic [15:0] pipe [LAT];
        for (int i = 0; i < LAT; i++) pipe[i] = 16'h0;
        ifc.atan_angle = 16'h0;
        forever begin
            @(posedge clk);
            for (int i = LAT - 1; i > 0; i--) pipe[i] = pipe[i-1];
            pipe[0] = ifc.atan_valid ? stub(ifc.atan_x, ifc.atan_y) : 16'($urandom);
            #1 ifc.atan_angle = pipe[LAT-1];
        end
    end

    // Downstream ready: 0 = always ready, 1 = random, 2 = stalled
    initial begin
        ifc.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 0)      ifc.out_ready = 1'b1;
            else if (ready_mode == 1) ifc.out_ready = ($urandom_range(0, 3) != 0);
            else                      ifc.out_ready = 1'b0;
        end
    end

    // Behavioural model, evaluated once per cycle away from the clock edge
    bit          pending  = 0;
    bit          prev_rst = 0;
    int          cyc      = 0;
    int          ta       = 0;
    logic [15:0] m_re [NR];
    logic [15:0] m_im [NR];
    logic [NR-1:0] m_mask = '0;
    logic [15:0] exp_ax [NR];
    logic [15:0] exp_ay [NR];
    logic [15:0] exp_phase = '0;
    logic [15:0] last_ax = '0;
    logic [15:0] last_ay = '0;
    bit          exp_first = 0;
    bit          exp_lastx = 0;

    initial begin
        int d;
        for (int k = 0; k < NR; k++) begin m_re[k] = '0; m_im[k] = '0; end
        forever begin
            @(negedge clk);
            cyc++;
            if (prev_rst) begin
                pending = 0;
                m_mask  = '0;
                for (int k = 0; k < NR; k++) begin m_re[k] = '0; m_im[k] = '0; end
                last_ax = '0;
                last_ay = '0;
                chk("rst_out_phase", ifc.out_phase, 16'h0);
            end
            if (pending) begin
                d = cyc - ta;
                if (d >= 1 && d <= NR) begin
                    last_ax = exp_ax[d-1];
                    last_ay = exp_ay[d-1];
                    chk("mon_atan_valid", ifc.atan_valid, 1'b1);
                end else begin
                    chk("mon_atan_valid", ifc.atan_valid, 1'b0);
                end
                chk("mon_atan_x", ifc.atan_x, last_ax);
                chk("mon_atan_y", ifc.atan_y, last_ay);
                chk("mon_in_ready_busy", ifc.in_ready, 1'b0);
                if (d >= NR + LAT + 1) begin
                    chk("mon_out_valid", ifc.out_valid, 1'b1);
                    chk("mon_out_phase", ifc.out_phase, exp_phase);
                    chk("mon_out_first", ifc.out_first, exp_first);
                    chk("mon_out_lastx", ifc.out_lastx, exp_lastx);
                    if (ifc.out_ready) pending = 0;
                end else begin
                    chk("mon_out_valid", ifc.out_valid, 1'b0);
                end
            end else begin
                chk("mon_in_ready_idle", ifc.in_ready, 1'b1);
                chk("mon_out_valid_idle", ifc.out_valid, 1'b0);
                chk("mon_atan_valid_idle", ifc.atan_valid, 1'b0);
                chk("mon_atan_x_hold", ifc.atan_x, last_ax);
                chk("mon_atan_y_hold", ifc.atan_y, last_ay);
                if (ifc.in_valid && !reset) begin
                    if (ifc.in_first) begin
                        for (int k = 0; k < NR; k++) begin
                            if (k < NZ) {m_re[k], m_im[k]} = cfg_zeros[32*k +: 32];
                            else        {m_re[k], m_im[k]} = cfg_poles[32*(k-NZ) +: 32];
                        end
                        m_mask = cfg_mask;
                    end
                    exp_phase = '0;
                    for (int k = 0; k < NR; k++) begin
                        exp_ax[k] = ifc.in_x - m_re[k];
                        exp_ay[k] = ifc.in_y - m_im[k];
                        if (m_mask[k]) begin
                            if (k < NZ) exp_phase = exp_phase + stub(exp_ax[k], exp_ay[k]);
                            else        exp_phase = exp_phase - stub(exp_ax[k], exp_ay[k]);
                        end
                    end
                    exp_first = ifc.in_first;
                    exp_lastx = ifc.in_lastx;
                    ta        = cyc;
                    pending   = 1;
                end
            end
            if (reset) pending = 0;
            prev_rst = reset;
        end
    end

    task automatic send(input logic [15:0] x, input logic [15:0] y, input bit first, input bit lastx);
        bit ok = 0;
        ifc.in_x     = x;
        ifc.in_y     = y;
        ifc.in_first = first;
        ifc.in_lastx = lastx;
        ifc.in_valid = 1'b1;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk);
            ok = ifc.in_ready && !reset;
            @(posedge clk);
            #1;
        end
        ifc.in_valid = 1'b0;
        if (!ok) timeout_fail("send");
    endtask

    task automatic wait_out(output int lat, output logic [15:0] ph);
        bit seen = 0;
        lat = 0;
        ph  = '0;
        for (int n = 1; n <= 60 && !seen; n++) begin
            @(negedge clk);
            if (ifc.out_valid) begin
                seen = 1;
                lat  = n;
                ph   = ifc.out_phase;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        if (seen) begin
            @(posedge clk);
            #1;
        end else begin
            timeout_fail("wait_out");
        end
    endtask

    task automatic set_zero(input int k, input logic [15:0] re, input logic [15:0] im);
        cfg_zeros[32*k +: 32] = {re, im};
    endtask

    initial begin
        int          lat;
        logic [15:0] ph;
        bit          first;

        ifc.in_valid = 1'b0;
        ifc.in_x     = '0;
        ifc.in_y     = '0;
        ifc.in_first = 1'b0;
        ifc.in_lastx = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        chk("reset_in_ready", ifc.in_ready, 1'b1);
        chk("reset_out_valid", ifc.out_valid, 1'b0);
        chk("reset_atan_valid", ifc.atan_valid, 1'b0);
        chk("reset_out_phase", ifc.out_phase, 16'h0);
        @(posedge clk);
        #1;

        // No frame start yet: shadow mask is still zero
        cfg_zeros = {$urandom, $urandom, $urandom, $urandom};
        cfg_mask  = 8'hFF;
        send(16'd123, 16'hFFF9, 1'b0, 1'b0);
        wait_out(lat, ph);
        chk("preframe_phase", ph, 16'h0);

        // Single zero
        cfg_zeros = '0;
        cfg_poles = '0;
        set_zero(0, 16'd10, 16'd20);
        cfg_mask = 8'h01;
        send(16'd30, 16'd25, 1'b1, 1'b0);
        wait_out(lat, ph);
        chk("c1_phase", ph, 16'h1405);
        chk("c1_latency", lat, 11);

        // Single pole subtracts and wraps
        cfg_zeros = '0;
        cfg_poles = '0;
        cfg_mask  = 8'h10;
        send(16'd0, 16'd1, 1'b1, 1'b0);
        wait_out(lat, ph);
        chk("c2_phase", ph, 16'hFFFF);

        // Config changes only take effect at frame start
        cfg_poles = '0;
        cfg_zeros = '0;
        set_zero(0, 16'd1, 16'd2);
        cfg_mask = 8'h01;
        send(16'd5, 16'd7, 1'b1, 1'b0);
        wait_out(lat, ph);
        chk("c3_frame_a", ph, 16'h0405);
        set_zero(0, 16'd0, 16'd0);
        set_zero(1, 16'd5, 16'd7);
        cfg_mask = 8'h03;
        send(16'd5, 16'd7, 1'b0, 1'b1);
        wait_out(lat, ph);
        chk("c3_midframe_a", ph, 16'h0405);
        send(16'd5, 16'd7, 1'b1, 1'b0);
        wait_out(lat, ph);
        chk("c3_frame_b", ph, 16'h0507);

        // Downstream stall holds the result
        cfg_zeros = '0;
        cfg_mask  = 8'h01;
        ready_mode = 2;
        @(posedge clk);
        #1;
        send(16'd3, 16'd4, 1'b1, 1'b1);
        wait_out(lat, ph);
        chk("c4_phase", ph, 16'h0304);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("c4_hold_valid", ifc.out_valid, 1'b1);
            chk("c4_hold_phase", ifc.out_phase, 16'h0304);
            chk("c4_hold_first", ifc.out_first, 1'b1);
            chk("c4_hold_lastx", ifc.out_lastx, 1'b1);
            chk("c4_hold_in_ready", ifc.in_ready, 1'b0);
        end
        ready_mode = 0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("c4_in_ready_after", ifc.in_ready, 1'b1);
        chk("c4_out_valid_after", ifc.out_valid, 1'b0);
        @(posedge clk);
        #1;

        // Reset while slot 3 is on the atan port, then restart immediately
        for (int k = 0; k < NZ; k++) set_zero(k, 16'(k + 1), 16'(k + 1));
        cfg_poles = {32'h00010002, 32'h00030004, 32'h00050006, 32'h00070008};
        cfg_mask  = 8'hFF;
        send(16'd100, 16'd50, 1'b1, 1'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("c5_out_valid", ifc.out_valid, 1'b0);
        chk("c5_atan_valid", ifc.atan_valid, 1'b0);
        cfg_zeros = '0;
        cfg_poles = '0;
        set_zero(0, 16'd10, 16'd20);
        cfg_mask = 8'h01;
        send(16'd30, 16'd25, 1'b1, 1'b0);
        wait_out(lat, ph);
        chk("c5_phase", ph, 16'h1405);
        chk("c5_latency", lat, 11);

        // Operand wrap
        cfg_zeros = '0;
        set_zero(0, 16'hFFFF, 16'h0000);
        cfg_mask = 8'h01;
        send(16'h7FFF, 16'h0000, 1'b1, 1'b0);
        @(negedge clk);
        chk("c6_atan_x", ifc.atan_x, 16'h8000);
        chk("c6_atan_valid", ifc.atan_valid, 1'b1);
        @(posedge clk);
        #1;
        wait_out(lat, ph);
        chk("c6_phase", ph, 16'h0000);

        // Randomized pixels, config churn and downstream backpressure
        ready_mode = 1;
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                cfg_zeros = {$urandom, $urandom, $urandom, $urandom};
                cfg_poles = {$urandom, $urandom, $urandom, $urandom};
                cfg_mask  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            end
            first = (i == 0) || ($urandom_range(0, 3) == 0);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            send(16'($urandom), 16'($urandom), first, 1'($urandom));
        end
        for (int n = 0; n < 100 && pending; n++) @(posedge clk);
        if (pending) timeout_fail("final_drain");
        @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
